// File: rtl/pool_apb_master.sv
// Single-outstanding command-to-APB bridge: IDLE -> SETUP -> ACCESS -> RESP.
// Optional ACCESS wait-state timeout enabled by defining APB_TIMEOUT_EN.
module pool_apb_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic                  CMD_WRITE,
    input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
    input  logic [DATA_WIDTH-1:0] CMD_WDATA,
    output logic                  RSP_VALID,
    output logic [DATA_WIDTH-1:0] RSP_RDATA,
    output logic                  RSP_ERR,
    output logic                  RSP_TIMEOUT,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    output logic                  BUSY,
    output logic [31:0]           XFER_COUNT
);

`ifdef APB_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam int unsigned   TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LIMIT = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t        state, next_state;
    logic          ready_en;
    logic          accept;
    logic          access_done;
    logic          timeout_hit;
    logic [TW-1:0] wait_cnt;

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state  = state;
        CMD_READY   = 1'b0;
        PSEL        = 1'b0;
        PENABLE     = 1'b0;
        RSP_VALID   = 1'b0;
        access_done = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                CMD_READY = ready_en;
                if (CMD_VALID && ready_en) next_state = SETUP;
            end
            SETUP: begin
                PSEL       = 1'b1;
                next_state = ACCESS;
            end
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (PREADY) begin
                    access_done = 1'b1;
                    next_state  = RESP;
                end else if (TIMEOUT_EN && (wait_cnt == T_LIMIT)) begin
                    access_done = 1'b1;
                    timeout_hit = 1'b1;
                    next_state  = RESP;
                end
            end
            RESP: begin
                RSP_VALID  = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign accept = CMD_VALID && CMD_READY;
    assign BUSY   = (state != IDLE);

    // ready_en keeps CMD_READY low during reset and for the first cycle after it
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ready_en    <= 1'b0;
            PADDR       <= '0;
            PWRITE      <= 1'b0;
            PWDATA      <= '0;
            RSP_RDATA   <= '0;
            RSP_ERR     <= 1'b0;
            RSP_TIMEOUT <= 1'b0;
            XFER_COUNT  <= '0;
            wait_cnt    <= '0;
        end else begin
            ready_en <= 1'b1;
            if (accept) begin
                PADDR  <= CMD_ADDR;
                PWRITE <= CMD_WRITE;
                PWDATA <= CMD_WDATA;
            end
            if (access_done) begin
                RSP_RDATA   <= (PWRITE || timeout_hit) ? '0 : PRDATA;
                RSP_ERR     <= timeout_hit | PSLVERR;
                RSP_TIMEOUT <= timeout_hit;
                XFER_COUNT  <= XFER_COUNT + 32'd1;
            end
            if (state == ACCESS && !PREADY) wait_cnt <= wait_cnt + TW'(1);
            else                            wait_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_pool_apb_master.sv
// Self-checking bench for pool_apb_master: vector table plus scoreboard of responses.
module tb_pool_apb_master;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        CMD_VALID, CMD_READY, CMD_WRITE;
    logic [31:0] CMD_ADDR, CMD_WDATA;
    logic        RSP_VALID, RSP_ERR, RSP_TIMEOUT;
    logic [31:0] RSP_RDATA;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic        BUSY;
    logic [31:0] XFER_COUNT;

    always #5 CLK = ~CLK;

    pool_apb_master #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
        .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .RSP_TIMEOUT(RSP_TIMEOUT),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .BUSY(BUSY), .XFER_COUNT(XFER_COUNT)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] prdata;
        logic        slverr;
        bit          hold;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
    } exp_t;

    exp_t        sb[$];
    exp_t        last;
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] cnt_exp;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_resp();
        exp_t e;
        chk("rsp_valid_pulse", 32'(RSP_VALID), 32'd1);
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_underflow: got response with no expected entry");
        end else begin
            e = sb.pop_front();
            last = e;
            cnt_exp = cnt_exp + 32'd1;
            chk("rsp_rdata",   RSP_RDATA,           e.rdata);
            chk("rsp_err",     32'(RSP_ERR),        32'(e.err));
            chk("rsp_timeout", 32'(RSP_TIMEOUT),    32'(e.tmo));
            chk("xfer_count",  XFER_COUNT,          cnt_exp);
        end
        chk("resp_psel",    32'(PSEL),    32'd0);
        chk("resp_penable", 32'(PENABLE), 32'd0);
    endtask

    task automatic run_xfer(input vec_t v);
        exp_t e;
        CMD_WRITE = v.wr;
        CMD_ADDR  = v.addr;
        CMD_WDATA = v.wdata;
        CMD_VALID = 1'b1;
        chk("idle_cmd_ready", 32'(CMD_READY), 32'd1);
        e.rdata = v.wr ? 32'd0 : v.prdata;
        e.err   = v.slverr;
        e.tmo   = 1'b0;
        sb.push_back(e);
        step();
        if (v.hold) begin
            CMD_WRITE = ~v.wr;
            CMD_ADDR  = ~v.addr;
            CMD_WDATA = ~v.wdata;
        end else begin
            CMD_VALID = 1'b0;
        end
        chk("setup_psel",      32'(PSEL),      32'd1);
        chk("setup_penable",   32'(PENABLE),   32'd0);
        chk("setup_paddr",     PADDR,          v.addr);
        chk("setup_pwrite",    32'(PWRITE),    32'(v.wr));
        chk("setup_pwdata",    PWDATA,         v.wdata);
        chk("setup_cmd_ready", 32'(CMD_READY), 32'd0);
        step();
        for (int k = 0; k <= v.waits; k++) begin
            PREADY  = (k == v.waits);
            PSLVERR = (k == v.waits) ? v.slverr : ~v.slverr;
            PRDATA  = (k == v.waits) ? v.prdata : ~v.prdata;
            chk("access_psel",      32'(PSEL),      32'd1);
            chk("access_penable",   32'(PENABLE),   32'd1);
            chk("access_paddr",     PADDR,          v.addr);
            chk("access_pwdata",    PWDATA,         v.wdata);
            chk("access_rsp_valid", 32'(RSP_VALID), 32'd0);
            chk("access_cmd_ready", 32'(CMD_READY), 32'd0);
            step();
        end
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        check_resp();
        chk("resp_cmd_ready", 32'(CMD_READY), 32'd0);
        step();
        chk("idle_rsp_valid", 32'(RSP_VALID), 32'd0);
        chk("idle_busy",      32'(BUSY),      32'd0);
        chk("hold_rdata",     RSP_RDATA,      last.rdata);
        chk("hold_err",       32'(RSP_ERR),   32'(last.err));
        chk("idle_ready",     32'(CMD_READY), 32'd1);
        CMD_VALID = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        exp_t e;
        vecs[0] = '{wr:1'b1, addr:32'h0000_0004, wdata:32'h0000_0010, waits:0, prdata:32'h1111_1111, slverr:1'b0, hold:1'b0};
        vecs[1] = '{wr:1'b0, addr:32'h0000_0008, wdata:32'h0000_0000, waits:3, prdata:32'hDEAD_BEEF, slverr:1'b0, hold:1'b0};
        vecs[2] = '{wr:1'b1, addr:32'h0000_0010, wdata:32'hCAFE_0001, waits:1, prdata:32'h0, slverr:1'b1, hold:1'b0};
        vecs[3] = '{wr:1'b0, addr:32'h0000_0020, wdata:32'h0, waits:0, prdata:32'h1234_5678, slverr:1'b1, hold:1'b0};
        vecs[4] = '{wr:1'b1, addr:32'hA5A5_0000, wdata:32'h5A5A_FFFF, waits:2, prdata:32'h0, slverr:1'b0, hold:1'b1};

        RESET = 1'b1; CMD_VALID = 1'b0; CMD_WRITE = 1'b0; CMD_ADDR = '0; CMD_WDATA = '0;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        cnt_exp = '0;
        last = '{rdata:32'd0, err:1'b0, tmo:1'b0};
        step(); step(); step();

        chk("rst_cmd_ready",  32'(CMD_READY),   32'd0);
        chk("rst_busy",       32'(BUSY),        32'd0);
        chk("rst_psel",       32'(PSEL),        32'd0);
        chk("rst_penable",    32'(PENABLE),     32'd0);
        chk("rst_paddr",      PADDR,            32'd0);
        chk("rst_rsp_valid",  32'(RSP_VALID),   32'd0);
        chk("rst_rsp_rdata",  RSP_RDATA,        32'd0);
        chk("rst_xfer_count", XFER_COUNT,       32'd0);
        RESET = 1'b0;
        chk("post_rst_ready_low", 32'(CMD_READY), 32'd0);
        step();
        chk("post_rst_ready_high", 32'(CMD_READY), 32'd1);

        // Reset while in ACCESS: transfer aborted without a response.
        CMD_WRITE = 1'b0; CMD_ADDR = 32'h0000_0040; CMD_VALID = 1'b1;
        step();
        CMD_VALID = 1'b0;
        step();
        chk("abort_in_access", 32'(PENABLE), 32'd1);
        RESET = 1'b1;
        step();
        chk("abort_psel",       32'(PSEL),      32'd0);
        chk("abort_penable",    32'(PENABLE),   32'd0);
        chk("abort_rsp_valid",  32'(RSP_VALID), 32'd0);
        chk("abort_busy",       32'(BUSY),      32'd0);
        chk("abort_xfer_count", XFER_COUNT,     cnt_exp);
        RESET = 1'b0;
        step();
        chk("abort_ready", 32'(CMD_READY), 32'd1);

        for (int i = 0; i < 5; i++) run_xfer(vecs[i]);

        // Wait-state handling with PREADY held low.
        CMD_WRITE = 1'b0; CMD_ADDR = 32'h0000_000C; CMD_VALID = 1'b1;
`ifdef APB_TIMEOUT_EN
        e = '{rdata:32'd0, err:1'b1, tmo:1'b1};
        sb.push_back(e);
        step();
        CMD_VALID = 1'b0;
        step();
        PRDATA = 32'hFFFF_FFFF;
        for (int k = 0; k < 8; k++) begin
            chk("tmo_penable",   32'(PENABLE),   32'd1);
            chk("tmo_rsp_valid", 32'(RSP_VALID), 32'd0);
            step();
        end
        check_resp();
        step();
        chk("tmo_idle", 32'(BUSY), 32'd0);
`else
        e = '{rdata:32'h0BAD_F00D, err:1'b0, tmo:1'b0};
        sb.push_back(e);
        step();
        CMD_VALID = 1'b0;
        step();
        PRDATA = 32'hFFFF_FFFF;
        for (int k = 0; k < 20; k++) begin
            chk("stall_busy",      32'(BUSY),      32'd1);
            chk("stall_rsp_valid", 32'(RSP_VALID), 32'd0);
            step();
        end
        PREADY = 1'b1; PRDATA = 32'h0BAD_F00D;
        step();
        PREADY = 1'b0;
        check_resp();
        step();
        chk("stall_idle", 32'(BUSY), 32'd0);
`endif

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pool_apb_master.md
POOL_APB_MASTER -- requirements
Module: pool_apb_master

Interface
REQ-001 SHALL have parameter: ADDR_WIDTH, 32, PADDR and CMD_ADDR width.
REQ-002 SHALL have parameter: DATA_WIDTH, 32, PWDATA, PRDATA, CMD_WDATA and RSP_RDATA width.
REQ-003 SHALL have parameter: TIMEOUT_CYCLES, 256, maximum number of ACCESS cycles with PREADY low; used only with APB_TIMEOUT_EN.
REQ-004 SHALL have port: CLK  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port: RESET  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port: CMD_VALID  input  1  command request.
REQ-007 SHALL have port: CMD_READY  output  1  command accepted when CMD_VALID && CMD_READY.
REQ-008 SHALL have port: CMD_WRITE  input  1  1 = write, 0 = read.
REQ-009 SHALL have ports: CMD_ADDR  input  ADDR_WIDTH  target address; CMD_WDATA  input  DATA_WIDTH  write data.
REQ-010 SHALL have ports: RSP_VALID  output  1  one-cycle completion pulse; RSP_RDATA  output  DATA_WIDTH  read data; RSP_ERR  output  1  PSLVERR or timeout; RSP_TIMEOUT  output  1  timeout flag.
REQ-011 SHALL have ports: PADDR  output  ADDR_WIDTH; PSEL  output  1; PENABLE  output  1; PWRITE  output  1; PWDATA  output  DATA_WIDTH.
REQ-012 SHALL have ports: PRDATA  input  DATA_WIDTH; PREADY  input  1; PSLVERR  input  1.
REQ-013 SHALL have ports: BUSY  output  1  high in any state except IDLE; XFER_COUNT  output  32  completed transfers.

Function
REQ-014 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP.
REQ-015 SHALL drive CMD_READY high only in IDLE.
REQ-016 SHALL, on acceptance, register CMD_WRITE/CMD_ADDR/CMD_WDATA into PWRITE/PADDR/PWDATA and go IDLE->SETUP.
REQ-017 SHALL drive PSEL=1, PENABLE=0 in SETUP, then go SETUP->ACCESS unconditionally.
REQ-018 SHALL drive PSEL=1, PENABLE=1 in ACCESS; stay while PREADY=0; on PREADY=1 go ACCESS->RESP.
REQ-019 SHALL hold PADDR, PWRITE, PWDATA stable from SETUP through end of ACCESS; in IDLE/RESP they hold last value.
REQ-020 SHALL, at ACCESS completion, capture PRDATA into RSP_RDATA for reads (0 for writes) and PSLVERR into RSP_ERR.
REQ-021 SHALL assert RSP_VALID exactly one cycle in RESP, PSEL=PENABLE=0, then return to IDLE.
REQ-022 SHALL hold RSP_RDATA/RSP_ERR/RSP_TIMEOUT until next completion.
REQ-023 SHALL give latency: accept cycle N -> SETUP N+1 -> ACCESS N+2 -> RSP_VALID N+3 with zero wait states; 4 cycles minimum per transfer.
REQ-024 SHALL increment XFER_COUNT by 1 per RSP_VALID (errors included), wrapping 0xFFFFFFFF->0.
REQ-025 SHALL ignore CMD_* inputs while not in IDLE.

Reset
REQ-026 SHALL, when RESET=1 at a clock edge, enter IDLE and set all outputs to 0 (CMD_READY becomes 1 the cycle after RESET deasserts).
REQ-027 SHALL abort any in-flight transfer on RESET with no RSP_VALID and no XFER_COUNT increment.

Configuration
REQ-028 SHALL, with APB_TIMEOUT_EN defined, count consecutive ACCESS cycles with PREADY=0; on reaching TIMEOUT_CYCLES, go to RESP with RSP_ERR=1, RSP_TIMEOUT=1, RSP_RDATA=0.
REQ-029 SHALL, without APB_TIMEOUT_EN, wait in ACCESS indefinitely and tie RSP_TIMEOUT to 0.

Verification
REQ-030 SHALL cover: write 0x0000_0004 <- 0x0000_0010, PREADY=1 -> PSEL N+1, PENABLE N+2, RSP_VALID N+3, RSP_ERR=0, XFER_COUNT=1.
REQ-031 SHALL cover: read 0x0000_0008, PREADY low 3 cycles, PRDATA=0xDEAD_BEEF -> ACCESS 4 cycles, RSP_RDATA=0xDEAD_BEEF, PADDR stable throughout.
REQ-032 SHALL cover: write with PSLVERR=1 at completion -> RSP_ERR=1, RSP_TIMEOUT=0, XFER_COUNT increments.
REQ-033 SHALL cover (APB_TIMEOUT_EN, TIMEOUT_CYCLES=8): PREADY never high -> RSP_VALID after 8 ACCESS cycles, RSP_ERR=1, RSP_TIMEOUT=1; without macro BUSY stays 1.
REQ-034 SHALL cover: RESET during ACCESS -> next cycle PSEL=PENABLE=0, RSP_VALID=0, XFER_COUNT unchanged; CMD_VALID held high during BUSY -> no second accept until IDLE.
